// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 core.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, KEYX, INIT, ROUND} state_t;

    localparam int NR = 10;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Bytes are stored column-major: byte (row r, column c) is index r + 4c.
    function automatic int bidx(input int r, input int c);
        return r + 4 * c;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] blk, input int i);
        return blk[127 - 8 * i -: 8];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box; inv selects the inverse box. Built from the GF(2^8)
// inverse plus the affine map, so forward and inverse share one inverter.
module aes_sbox
    import aes_pkg::*;
(
    input  logic       inv,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        p = a;
        for (int i = 0; i < 6; i++) p = gmul(gmul(p, p), a);
        return gmul(p, p);
    endfunction

    logic [7:0] pre;
    logic [7:0] g;

    always_comb begin
        pre  = inv ? (rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05) : din;
        g    = gf_inv(pre);
        dout = inv ? g
                   : (g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63);
    end

endmodule

// File: rtl/aes_128.sv
// Iterative AES-128 encrypt/decrypt core: key expansion, then one round per clock.
// Optional AES_128_KEY_CACHE_EN skips key expansion when the key is unchanged.
module aes_128
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         encrypt,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         done
);

    state_t       state;
    logic         enc_reg;
    logic [127:0] blk_reg;
    logic [127:0] state_reg;
    logic [3:0]   cnt;
    logic [127:0] rk [NR + 1];

`ifdef AES_128_KEY_CACHE_EN
    logic         cache_valid;
    logic [127:0] cache_key;
`endif

    // Key expansion: rk[cnt] from rk[cnt-1].
    logic [3:0]   kx_idx;
    logic [127:0] kx_prev;
    logic [127:0] kx_next;
    logic [31:0]  kx_rot;
    logic [31:0]  kx_sub;
    logic [31:0]  kx_tmp;

    assign kx_idx  = cnt - 4'd1;
    assign kx_prev = rk[kx_idx];
    assign kx_rot  = {kx_prev[23:0], kx_prev[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_kx_sbox
        aes_sbox u_sbox (.inv(1'b0), .din(kx_rot[31 - 8 * k -: 8]), .dout(kx_sub[31 - 8 * k -: 8]));
    end

    always_comb begin
        kx_tmp           = kx_sub ^ {RCON[kx_idx], 24'h0};
        kx_next[127:96]  = kx_prev[127:96] ^ kx_tmp;
        kx_next[95:64]   = kx_prev[95:64]  ^ kx_next[127:96];
        kx_next[63:32]   = kx_prev[63:32]  ^ kx_next[95:64];
        kx_next[31:0]    = kx_prev[31:0]   ^ kx_next[63:32];
    end

    // Round datapath. SubBytes and ShiftRows commute, so the S-boxes sit first
    // for both directions and only the row rotation changes with enc_reg.
    logic [7:0]   sb_out [16];
    logic [7:0]   sr     [16];
    logic [7:0]   pre    [16];
    logic [7:0]   mixed  [16];
    logic [3:0]   rk_idx;
    logic [127:0] rkey;
    logic         last;
    logic [127:0] round_out;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (.inv(~enc_reg), .din(get_byte(state_reg, i)), .dout(sb_out[i]));
    end

    assign rk_idx = enc_reg ? cnt : 4'(NR) - cnt;
    assign rkey   = rk[rk_idx];
    assign last   = (cnt == 4'(NR));

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        round_out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[bidx(r, c)] = enc_reg ? sb_out[bidx(r, (c + r) % 4)]
                                         : sb_out[bidx(r, (c + 4 - r) % 4)];
            end
        end
        for (int i = 0; i < 16; i++) begin
            pre[i] = enc_reg ? sr[i] : (sr[i] ^ get_byte(rkey, i));
        end
        for (int c = 0; c < 4; c++) begin
            a0 = pre[bidx(0, c)];
            a1 = pre[bidx(1, c)];
            a2 = pre[bidx(2, c)];
            a3 = pre[bidx(3, c)];
            if (enc_reg) begin
                mixed[bidx(0, c)] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                mixed[bidx(1, c)] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                mixed[bidx(2, c)] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                mixed[bidx(3, c)] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
                mixed[bidx(0, c)] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                mixed[bidx(1, c)] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                mixed[bidx(2, c)] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                mixed[bidx(3, c)] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (enc_reg) round_out[127 - 8 * i -: 8] = (last ? pre[i] : mixed[i]) ^ get_byte(rkey, i);
            else         round_out[127 - 8 * i -: 8] = last ? pre[i] : mixed[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            enc_reg    <= 1'b0;
            blk_reg    <= '0;
            state_reg  <= '0;
            cnt        <= '0;
            ciphertext <= '0;
            done       <= 1'b0;
            // NOTE: the key store is cleared on reset so no key material from an aborted run survives.
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
`ifdef AES_128_KEY_CACHE_EN
            cache_valid <= 1'b0;
            cache_key   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        blk_reg <= plaintext;
                        enc_reg <= encrypt;
                        rk[0]   <= key;
                        done    <= 1'b0;
`ifdef AES_128_KEY_CACHE_EN
                        if (cache_valid && key == cache_key) begin
                            state <= INIT;
                        end else begin
                            cache_valid <= 1'b0;
                            cache_key   <= key;
                            cnt         <= 4'd1;
                            state       <= KEYX;
                        end
`else
                        cnt   <= 4'd1;
                        state <= KEYX;
`endif
                    end
                end
                KEYX: begin
                    rk[cnt] <= kx_next;
                    if (last) begin
                        state <= INIT;
`ifdef AES_128_KEY_CACHE_EN
                        cache_valid <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                INIT: begin
                    state_reg <= blk_reg ^ (enc_reg ? rk[0] : rk[NR]);
                    cnt       <= 4'd1;
                    state     <= ROUND;
                end
                ROUND: begin
                    state_reg <= round_out;
                    if (last) begin
                        ciphertext <= round_out;
                        done       <= 1'b1;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128.sv
// Self-checking bench for aes_128: FIPS-197 vectors, busy/reset corner cases and
// random operations against a table-driven AES reference model.
module tb_aes_128;

    logic         clk;
    logic         rst;
    logic         start;
    logic         encrypt;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    bit           tb_cache_valid = 0;
    logic [127:0] tb_cache_key   = '0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_128 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .encrypt   (encrypt),
        .plaintext (plaintext),
        .key       (key),
        .ciphertext(ciphertext),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // S-box generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p = 8'h01;
        logic [7:0] q = 8'h01;
        logic [7:0] x;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        while (b != 0) begin
            if (b[0]) r = r ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return r;
    endfunction

    // Textbook cipher / inverse cipher over a 4x4 byte matrix.
    function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] blk, input bit enc);
        logic [31:0]  w  [44];
        logic [7:0]   kb [11][16];
        logic [7:0]   s  [16];
        logic [7:0]   t  [16];
        logic [7:0]   cf [4];
        logic [7:0]   rc = 8'h01;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gm(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            for (int i = 0; i < 16; i++) kb[r][i] = w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        for (int i = 0; i < 16; i++) s[i] = blk[127 - 8 * i -: 8];
        if (enc) cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        else     cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        if (enc) begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ kb[0][i];
            for (int r = 1; r <= 10; r++) begin
                for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4 * ((i / 4 + i % 4) % 4)]];
                for (int i = 0; i < 16; i++) begin
                    if (r < 10) begin
                        s[i] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[i] = s[i] ^ gm(cf[(j - i % 4 + 4) % 4], t[4 * (i / 4) + j]);
                    end else begin
                        s[i] = t[i];
                    end
                end
                for (int i = 0; i < 16; i++) s[i] = s[i] ^ kb[r][i];
            end
        end else begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ kb[10][i];
            for (int r = 9; r >= 0; r--) begin
                for (int i = 0; i < 16; i++)
                    t[i] = isbox[s[(i % 4) + 4 * ((i / 4 - i % 4 + 4) % 4)]] ^ kb[r][i];
                for (int i = 0; i < 16; i++) begin
                    if (r > 0) begin
                        s[i] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[i] = s[i] ^ gm(cf[(j - i % 4 + 4) % 4], t[4 * (i / 4) + j]);
                    end else begin
                        s[i] = t[i];
                    end
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    function automatic int exp_latency(input logic [127:0] k);
`ifdef AES_128_KEY_CACHE_EN
        return (tb_cache_valid && k == tb_cache_key) ? 11 : 21;
`else
        return 21;
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Presents one start pulse; ports are scrambled right after acceptance.
    task automatic launch(input string tag, input bit enc, input logic [127:0] blk, input logic [127:0] k);
        @(negedge clk);
        start     = 1'b1;
        encrypt   = enc;
        plaintext = blk;
        key       = k;
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, 128'(done), 128'(0));
        @(negedge clk);
        start     = 1'b0;
        encrypt   = ~enc;
        plaintext = rand128();
        key       = rand128();
    endtask

    task automatic wait_done(input string tag, input int n0, input int exp_lat, input logic [127:0] exp_ct,
                             input logic [127:0] k);
        int n = n0;
        logic [127:0] held;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 60);
        check({tag, "_lat"}, 128'(n), 128'(exp_lat));
        check({tag, "_ct"}, ciphertext, exp_ct);
        held = ciphertext;
        repeat (3) @(negedge clk);
        check({tag, "_hold_done"}, 128'(done), 128'(1));
        check({tag, "_hold_ct"}, ciphertext, held);
        tb_cache_valid = 1;
        tb_cache_key   = k;
    endtask

    task automatic run_op(input string tag, input bit enc, input logic [127:0] blk, input logic [127:0] k,
                          input logic [127:0] exp_ct);
        int lat = exp_latency(k);
        launch(tag, enc, blk, k);
        wait_done(tag, 0, lat, exp_ct, k);
    endtask

    initial begin
        logic [127:0] rk;
        logic [127:0] rb;
        bit           re;
        int           lat;

        build_sbox();
        rst       = 1'b0;
        start     = 1'b0;
        encrypt   = 1'b0;
        plaintext = '0;
        key       = '0;
        #3;
        check("reset_done", 128'(done), 128'(0));
        check("reset_ct", ciphertext, 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op("c1_enc", 1'b1, C1_PT, C1_KEY, C1_CT);
        run_op("c1_dec", 1'b0, C1_CT, C1_KEY, C1_PT);
        run_op("b_enc", 1'b1, B_PT, B_KEY, B_CT);
        run_op("b_dec", 1'b0, B_CT, B_KEY, B_PT);

        // A second start while busy must be ignored.
        lat = exp_latency(C1_KEY);
        launch("busy", 1'b1, C1_PT, C1_KEY);
        repeat (4) @(negedge clk);
        start     = 1'b1;
        encrypt   = 1'b0;
        plaintext = B_CT;
        key       = B_KEY;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy", 5, lat, C1_CT, C1_KEY);
        repeat (25) @(negedge clk);
        check("busy_no_extra_done", 128'(done), 128'(1));
        check("busy_no_extra_ct", ciphertext, C1_CT);

        // Reset in the middle of an operation aborts it.
        rk = rand128();
        launch("rst_mid", 1'b1, C1_PT, rk);
        repeat (11) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_done", 128'(done), 128'(0));
        check("rst_mid_ct", ciphertext, 128'(0));
        @(negedge clk);
        check("rst_hold_done", 128'(done), 128'(0));
        check("rst_hold_ct", ciphertext, 128'(0));
        rst = 1'b1;
        tb_cache_valid = 0;
        run_op("c1_after_rst", 1'b1, C1_PT, C1_KEY, C1_CT);

        // Random operations; keys are reused often so a key cache gets hits.
        rk = rand128();
        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 0) rk = rand128();
            rb = rand128();
            re = 1'($urandom);
            run_op($sformatf("rand%0d", i), re, rb, rk, ref_aes(rk, rb, re));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_128.md
Name: aes_128

Overview:
- Iterative AES-128 (FIPS-197) block cipher core; one 128-bit block per operation, encrypt or decrypt chosen per operation.
- Expands the key into 11 stored round keys, then executes one round per clock.
- Sits behind a simple start/done handshake as a memory-mapped crypto accelerator datapath.

Parameters:
- None. AES-128 is fixed: Nk=4, Nr=10.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled in IDLE only.
- encrypt  input  1  1 = encrypt, 0 = decrypt; latched with start.
- plaintext  input  128  input block (plaintext, or ciphertext when decrypting); latched with start. Byte 0 is bits [127:120].
- key  input  128  cipher key; latched with start.
- ciphertext  output  128  result block (ciphertext, or recovered plaintext when decrypting).
- done  output  1  result-valid flag.

Behaviour:
- Reset (rst=0, async): state=IDLE, ciphertext=0, done=0, round counter=0, round-key store cleared.
- States: IDLE -> KEYX -> INIT -> ROUND -> IDLE.
- IDLE, start=1 at edge E:
  - Latch plaintext, key and encrypt into internal registers.
  - rk0=key.
  - Clear done.
  - Go to KEYX with count=1.
- KEYX (edges E+1..E+10): compute rk[i] from rk[i-1] with RotWord/SubWord/Rcon[i], one key per edge; after rk10, go to INIT.
- INIT (edge E+11): state_reg = block ^ rk0 for encrypt, or block ^ rk10 for decrypt; round=1.
- ROUND (edges E+12..E+21):
  - Encrypt, rounds 1-9: SubBytes, ShiftRows, MixColumns, then XOR rk[round].
  - Encrypt, round 10: omit MixColumns.
  - Decrypt, rounds 1-9: InvShiftRows, InvSubBytes, XOR rk[10-round], then InvMixColumns.
  - Decrypt, round 10: XOR rk0 with no InvMixColumns.
  - At round 10: ciphertext <= result, done <= 1, go to IDLE.
- Latency: done rises at edge E+21 (21 cycles after the accepting edge).
- done and ciphertext remain stable until the next accepted start.
- done clears on the edge that accepts the next start, so a bench waiting on done never sees a stale result.
- start while not IDLE is ignored; there is no queueing.
- Input port changes after acceptance do not affect the running operation.
- start and done in the same cycle (in IDLE): the new operation is accepted and done clears.
- Reset mid-operation: abort immediately, outputs return to reset values, and no partial result is ever presented.
- MixColumns uses GF(2^8) with polynomial 0x11B: xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0). InvMixColumns uses multipliers 9, 11, 13, 14.

Optional Feature:
- Macro: AES_128_KEY_CACHE_EN.
- When defined:
  - Keep a valid flag and a copy of the last expanded key.
  - If the key at start equals the cached key and the flag is set, skip KEYX and go straight to INIT. Latency drops to 11 cycles, with done at edge E+11.
  - The flag is cleared by reset.
- When undefined: always run KEYX; latency is 21 cycles.

Decomposition:
- Package aes_pkg holds:
  - the state enum (IDLE, KEYX, INIT, ROUND);
  - NR=10;
  - the Rcon constant table (01,02,04,08,10,20,40,80,1B,36);
  - xtime/gmul functions;
  - the byte/column indexing helpers.
- Sub-module aes_sbox:
  - Combinational, 8-bit in/out, with input inv selecting the forward or inverse S-box.
  - Instantiate 16 copies for the datapath and 4 for key expansion.
- Everything else (ShiftRows, MixColumns, round-key store, FSM) lives in aes_128.

Test Plan:
- FIPS-197 C.1, encrypt: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, done exactly 21 cycles after start.
- C.1 decrypt round trip: encrypt=0, input 69c4e0d86a7b0430d8cdb78070b4c55a, same key -> 00112233445566778899aabbccddeeff. done must drop on the accepting edge and re-rise 21 cycles later.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; decrypt returns the pt.
- Busy/ignore: pulse start again at cycle 5 with different data -> result still matches the first operation; no extra done.
- Reset mid-operation: assert rst=0 at cycle 12 -> done=0 and ciphertext=0 immediately. A fresh C.1 encrypt afterwards is correct.
- With AES_128_KEY_CACHE_EN: back-to-back C.1 encrypt then decrypt with the same key -> second done 11 cycles after start. A changed key falls back to 21 cycles.
